// File: rtl/wims_pkg.sv
// wims_pkg: shared state encoding and nibble width for the NOR operation sequencer.
package wims_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EVAL   = 2'd2,
        HOLD   = 2'd3
    } state_t;
endpackage

// File: rtl/nor_op_sequencer_if.sv
// nor_op_sequencer_if: operand/result handshake bundle; zero flag present when NOR_SEQ_ZERO_FLAG_EN is defined.
interface nor_op_sequencer_if;
    import wims_pkg::*;
    logic                in_valid;
    logic                in_ready;
    logic [NIBBLE_W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NIBBLE_W-1:0] out_y;
    logic                busy;
`ifdef NOR_SEQ_ZERO_FLAG_EN
    logic                zero;
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_y, busy, zero);
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_y, busy, zero);
`else
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_y, busy);
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_y, busy);
`endif
endinterface

// File: rtl/ls7402.sv
// ls7402: quad 2-input NOR gate.
module ls7402
    import wims_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic [NIBBLE_W-1:0] y
);
    assign y = ~(a | b);
endmodule

// File: rtl/nor_op_sequencer.sv
// nor_op_sequencer: accepts operands A then B, settles EVAL_CYCLES, holds ~(A|B) until consumed.
// Optional registered zero flag enabled by NOR_SEQ_ZERO_FLAG_EN.
module nor_op_sequencer
    import wims_pkg::*;
#(
    parameter int EVAL_CYCLES = 1
) (
    input logic               clk,
    input logic               rst,
    nor_op_sequencer_if.slave bus
);
    localparam int         EFF_CYCLES = (EVAL_CYCLES < 1) ? 1 : EVAL_CYCLES;
    localparam logic [2:0] CNT_INIT   = 3'(EFF_CYCLES - 1);

    if (EVAL_CYCLES > 7) begin : g_range_err
        $error("nor_op_sequencer: EVAL_CYCLES must be within 1..7");
    end

    state_t              state_q, state_d;
    logic [NIBBLE_W-1:0] a_q, a_d, b_q, b_d, y_q, y_d, nor_y;
    logic [2:0]          cnt_q, cnt_d;
    logic                xfer;

    ls7402 u_nor (.a(a_q), .b(b_q), .y(nor_y));

    assign bus.in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign bus.out_valid = state_q == HOLD;
    assign bus.busy      = state_q != LOAD_A;
    assign bus.out_y     = y_q;
    assign xfer          = bus.in_valid & bus.in_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        unique case (state_q)
            LOAD_A: if (xfer) begin
                a_d     = bus.in_data;
                state_d = LOAD_B;
            end
            LOAD_B: if (xfer) begin
                b_d     = bus.in_data;
                cnt_d   = CNT_INIT;
                state_d = EVAL;
            end
            EVAL: if (cnt_q == 3'd0) begin
                y_d     = nor_y;
                state_d = HOLD;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
            HOLD: if (bus.out_ready) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

`ifdef NOR_SEQ_ZERO_FLAG_EN
    // Updated only on result capture so reset's all-zero out_y never reads as a zero result.
    logic zero_q, zero_d;
    assign zero_d   = (state_q == EVAL && cnt_q == 3'd0) ? (nor_y == '0) : zero_q;
    assign bus.zero = zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) zero_q <= 1'b0;
        else     zero_q <= zero_d;
    end
`endif
endmodule

// File: tb/tb_nor_op_sequencer.sv
// tb_nor_op_sequencer: directed and randomized checks of two sequencers (EVAL_CYCLES 1 and 3) against a NOR/latency model.
module tb_nor_op_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic [3:0] last_y [2];
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       in_ready_o, out_valid_o, busy_o;
    logic [3:0] out_y_o;

    nor_op_sequencer_if b1 ();
    nor_op_sequencer_if b3 ();

    nor_op_sequencer #(.EVAL_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    nor_op_sequencer #(.EVAL_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    assign b1.in_valid  = in_valid & ~sel;
    assign b3.in_valid  = in_valid & sel;
    assign b1.in_data   = in_data;
    assign b3.in_data   = in_data;
    assign b1.out_ready = out_ready & ~sel;
    assign b3.out_ready = out_ready & sel;

    assign in_ready_o  = sel ? b3.in_ready  : b1.in_ready;
    assign out_valid_o = sel ? b3.out_valid : b1.out_valid;
    assign busy_o      = sel ? b3.busy      : b1.busy;
    assign out_y_o     = sel ? b3.out_y     : b1.out_y;
`ifdef NOR_SEQ_ZERO_FLAG_EN
    logic zero_o;
    assign zero_o = sel ? b3.zero : b1.zero;
`endif

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s sel=%0d observed=%b expected=%b", tag, sel, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s sel=%0d observed=%h expected=%h", tag, sel, obs, exp);
        end
    endtask

    task automatic reset_state_checks();
        chk1("rst_in_ready", in_ready_o, 1'b1);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_out_valid", out_valid_o, 1'b0);
        chk4("rst_out_y", out_y_o, 4'h0);
`ifdef NOR_SEQ_ZERO_FLAG_EN
        chk1("rst_zero", zero_o, 1'b0);
`endif
    endtask

    // One full operation: optional idle and inter-beat stalls, settle, then hold under backpressure.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input int stalls, input int hold);
        logic [3:0] exp;
        int         lat;
        exp = ~(a | b);
        lat = sel ? 3 : 1;
        chk4("idle_y_kept", out_y_o, last_y[sel]);
        chk1("idle_busy", busy_o, 1'b0);
        chk1("idle_in_ready", in_ready_o, 1'b1);
        for (int i = 0; i < stalls; i++) begin
            in_valid = 1'b0; in_data = 4'($urandom); out_ready = 1'($urandom);
            @(negedge clk);
            chk1("pre_a_busy", busy_o, 1'b0);
        end
        in_valid = 1'b1; in_data = a; out_ready = 1'($urandom);
        @(negedge clk);
        chk1("a_busy", busy_o, 1'b1);
        chk1("a_in_ready", in_ready_o, 1'b1);
        for (int i = 0; i < stalls; i++) begin
            in_valid = 1'b0; in_data = 4'($urandom);
            @(negedge clk);
            chk1("stall_in_ready", in_ready_o, 1'b1);
            chk1("stall_out_valid", out_valid_o, 1'b0);
        end
        in_valid = 1'b1; in_data = b;
        @(negedge clk);
        for (int i = 1; i <= lat; i++) begin
            in_valid = 1'($urandom); in_data = 4'($urandom); out_ready = 1'($urandom);
            chk1("eval_out_valid", out_valid_o, 1'b0);
            chk1("eval_in_ready", in_ready_o, 1'b0);
            chk1("eval_busy", busy_o, 1'b1);
            @(negedge clk);
        end
        chk1("res_out_valid", out_valid_o, 1'b1);
        chk4("res_out_y", out_y_o, exp);
`ifdef NOR_SEQ_ZERO_FLAG_EN
        chk1("res_zero", zero_o, exp == 4'h0);
`endif
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom); in_data = 4'($urandom);
            @(negedge clk);
            chk1("hold_out_valid", out_valid_o, 1'b1);
            chk4("hold_out_y", out_y_o, exp);
            chk1("hold_in_ready", in_ready_o, 1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk1("exit_in_ready", in_ready_o, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        chk1("done_out_valid", out_valid_o, 1'b0);
        chk4("done_out_y", out_y_o, exp);
        chk1("done_busy", busy_o, 1'b0);
        chk1("done_in_ready", in_ready_o, 1'b1);
        last_y[sel] = exp;
    endtask

    initial begin
        last_y[0] = 4'h0;
        last_y[1] = 4'h0;
        #12;
        reset_state_checks();
        sel = 1'b1;
        #1 reset_state_checks();
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(4'b0000, 4'b0011, 0, 0);
        do_op(4'b1010, 4'b0110, 0, 5);
        do_op(4'b1100, 4'b0101, 2, 1);
        in_valid = 1'b1; in_data = 4'b1111;
        @(negedge clk);
        in_valid = 1'b0;
        chk1("pre_abort_busy", busy_o, 1'b1);
        rst = 1'b1;
        #1 reset_state_checks();
        @(negedge clk);
        rst = 1'b0;
        last_y[0] = 4'h0;
        last_y[1] = 4'h0;
        do_op(4'b0000, 4'b0000, 0, 0);
        do_op(4'b1111, 4'b0000, 0, 1);
        do_op(4'b0000, 4'b0000, 1, 0);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clk);
            do_op(4'b0000, 4'b0011, 0, 2);
            for (int n = 0; n < 8; n++)
                do_op(4'($urandom), 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nor_op_sequencer.md
NOR_OP_SEQUENCER -- requirements
Module: nor_op_sequencer

Interface
REQ-001 SHALL have parameter EVAL_CYCLES, default 1: settle cycles between operand B capture and result capture; legal range 1..7.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: in_data holds a valid operand nibble.
REQ-005 SHALL have port in_ready, output, 1: block accepts an operand this cycle.
REQ-006 SHALL have port in_data, input, 4: operand nibble; first beat = A, second beat = B.
REQ-007 SHALL have port out_valid, output, 1: out_y holds a captured result.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-009 SHALL have port out_y, output, 4: registered result, ~(A | B) bitwise.
REQ-010 SHALL have port busy, output, 1: high in any state other than LOAD_A.

Function
REQ-011 SHALL implement the FSM states LOAD_A, LOAD_B, EVAL and HOLD.
REQ-012 SHALL set in_ready=1 only in LOAD_A and LOAD_B; elsewhere 0; in_ready SHALL NOT depend combinationally on in_valid.
REQ-013 SHALL complete an input transfer only on a clk edge with in_valid & in_ready both high.
REQ-014 SHALL capture A and move LOAD_A->LOAD_B on a transfer in LOAD_A; SHALL otherwise hold.
REQ-015 SHALL capture B, load the 3-bit settle counter with EVAL_CYCLES-1 and move LOAD_B->EVAL on a transfer in LOAD_B.
REQ-016 SHALL decrement the counter in EVAL; when it is 0, the same edge SHALL register ~(A|B) into out_y and move to HOLD.
REQ-017 SHALL give latency: B accepted at edge k -> out_valid=1 after edge k+EVAL_CYCLES.
REQ-018 SHALL hold out_valid=1 and a stable out_y throughout HOLD until an edge with out_ready=1, then move to LOAD_A with out_valid=0.
REQ-019 SHALL keep out_y at its last value after the HOLD->LOAD_A transition; only the next EVAL capture changes it.
REQ-020 SHALL ignore out_ready outside HOLD and in_valid outside LOAD_A/LOAD_B.
REQ-021 SHALL NOT overlap operations: in_ready SHALL NOT be asserted in the HOLD->LOAD_A exit cycle.
REQ-022 SHALL route an out-of-range EVAL_CYCLES of 0 to behave as 1, and fail elaboration (assertion) above 7.

Reset
REQ-023 SHALL, while rst=1, force state LOAD_A, A=B=0, counter=0, out_y=0000, out_valid=0; in_ready=1 and busy=0 follow from LOAD_A.
REQ-024 SHALL abort any partial operation on reset mid-sequence (any state), discarding captured operands; no result is emitted for it.

Configuration
REQ-025 SHALL, when NOR_SEQ_ZERO_FLAG_EN is defined, add output zero, 1 bit, registered with out_y, high when captured result = 0000, reset 0.
REQ-026 SHALL, when NOR_SEQ_ZERO_FLAG_EN is undefined, omit the zero port and its register entirely; all other behaviour is identical.

Structure
REQ-027 SHALL take the state encoding typedef (2-bit enum LOAD_A=0, LOAD_B=1, EVAL=2, HOLD=3) and the nibble width constant (4) from the shared package wims_pkg.
REQ-028 SHALL compute ~(A|B) by instantiating the existing ls7402 quad-NOR block as its single sub-module, with a=A, b=B; no other sub-modules.

Verification
REQ-029 SHALL cover basic operation: A=0000, B=0011, out_ready=1 -> out_y=1100, out_valid one cycle, EVAL_CYCLES=1 latency of 1 edge after B.
REQ-030 SHALL cover backpressure: A=1010, B=0110, out_ready=0 for 5 cycles -> out_y=0001 and out_valid=1 stable all 5 cycles, in_ready=0; release -> LOAD_A.
REQ-031 SHALL cover input stalls: in_valid toggled 1/0 between beats -> only handshaked beats captured; A=1100, B=0101 -> 0010.
REQ-032 SHALL cover reset mid-operation: rst pulsed after A=1111 accepted, then A=0000, B=0000 -> out_y=1111, with no result for the aborted pair.
REQ-033 SHALL cover EVAL_CYCLES=3: B accepted at edge k -> out_valid rises after edge k+3, busy=1 from A accept to HOLD exit.
REQ-034 SHALL cover the zero flag with NOR_SEQ_ZERO_FLAG_EN defined: A=1111, B=0000 -> out_y=0000, zero=1; then A=0000, B=0000 -> zero=0.
